// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arithmetic/compare ops and iterative
// shifts (one bit position per cycle) behind valid/ready handshakes.
module alu_multicycle #(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       Operation,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    // state | meaning
    // IDLE  | waiting for an operation
    // SHIFT | shifting the accumulator one bit per cycle
    // DONE  | result presented, waiting for the consumer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_BEQ = 4'b1000;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     acc_step;
    logic [SHAMT_W-1:0]   cnt;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     result;
    logic                 zero;
    logic [WIDTH-1:0]     alu_res;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic                 long_shift;
    logic                 accept;
    logic                 last_step;
    logic                 lt;
    logic                 eq;

    assign shamt      = SrcB[SHAMT_W-1:0];
    assign is_shift   = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
    assign long_shift = is_shift && (shamt != '0);
    assign InReady    = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept     = InValid && InReady;
    assign last_step  = (cnt == SHAMT_W'(1));
    assign lt         = $signed(SrcA) < $signed(SrcB);
    assign eq         = (SrcA == SrcB);

    assign OutValid   = (state == DONE);
    assign ALUResult  = result;
    assign Zero       = zero;

    // Shift ops only reach this path with a zero shift amount.
    always_comb begin
        alu_res = '0;
        case (Operation)
            OP_AND:                 alu_res = SrcA & SrcB;
            OP_OR:                  alu_res = SrcA | SrcB;
            OP_ADD:                 alu_res = SrcA + SrcB;
            OP_SUB:                 alu_res = SrcA - SrcB;
            OP_SLL, OP_SRL, OP_SRA: alu_res = SrcA;
            OP_SLT:                 alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_BEQ:                 alu_res = {{(WIDTH-1){1'b0}}, eq};
            default:                alu_res = '0;
        endcase
    end

    always_comb begin
        acc_step = acc;
        case (op_q)
            OP_SLL:  acc_step = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc[WIDTH-1:1]};
            default: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = long_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    if (InValid) begin
                        state_next = long_shift ? SHIFT : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else if (accept) begin
            if (long_shift) begin
                acc  <= SrcA;
                cnt  <= shamt;
                op_q <= Operation;
            end else begin
                result <= alu_res;
                zero   <= (alu_res == '0);
            end
        end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - SHAMT_W'(1);
            if (last_step) begin
                result <= acc_step;
                zero   <= (acc_step == '0);
            end
        end
    end

endmodule
